// File: rtl/aurora_reset_sequencer.sv
// aurora_reset_sequencer
//
// Brings up one or more Aurora channels: holds the GT and the core in reset
// for fixed intervals, waits for a debounced channel_up, and re-runs the whole
// sequence if the link does not come up in time. After too many attempts the
// channel parks in a failed state until force_reinit or RST.
//
// Ports
//   init_clk           clock, rising edge
//   RST                synchronous active-high reset
//   channel_up[N]      per-channel CORE_STATUS channel_up (asynchronous)
//   force_reinit[N]    one-cycle pulse, restarts that channel's sequence
//   gt_reset[N]        to Aurora gt_reset
//   reset_Aurora[N]    to Aurora reset
//   reset_TX_RX_Block[N] to the FIFO bridge resets, low only while linked
//   link_ok[N]         high while the channel is linked
//   link_fail[N]       high while the channel has given up
//   retry_cnt[4N]      per-channel retry count, channel i at [4i+3:4i]
module aurora_reset_sequencer #(
    parameter int N_CH      = 1,
    parameter int GT_HOLD   = 14,
    parameter int CORE_HOLD = 4,
    parameter int DEB_LEN   = 8,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 3
) (
    input  logic                init_clk,
    input  logic                RST,
    input  logic [N_CH-1:0]     channel_up,
    input  logic [N_CH-1:0]     force_reinit,
    output logic [N_CH-1:0]     gt_reset,
    output logic [N_CH-1:0]     reset_Aurora,
    output logic [N_CH-1:0]     reset_TX_RX_Block,
    output logic [N_CH-1:0]     link_ok,
    output logic [N_CH-1:0]     link_fail,
    output logic [4*N_CH-1:0]   retry_cnt
);

    typedef enum logic [2:0] {
        RESET_GT   = 3'd0,
        RESET_CORE = 3'd1,
        WAIT_UP    = 3'd2,
        DEBOUNCE   = 3'd3,
        LINKED     = 3'd4,
        FAILED     = 3'd5
    } state_t;

    // One shared counter per channel serves the two hold phases, the WAIT_UP
    // timer and the debounce count, since only one is live in any state.
    localparam int HOLD_MAX = (GT_HOLD > CORE_HOLD) ? GT_HOLD : CORE_HOLD;
    localparam int CNT_MAX  = (TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   GT_LAST   = CNT_W'(GT_HOLD - 1);
    localparam logic [CNT_W-1:0]   CORE_LAST = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEB_LEN - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic               ch_up_meta_reg = 1'b0;
        logic               ch_up_s_reg    = 1'b0;
        state_t             state_reg      = RESET_GT;
        state_t             state_next;
        logic [CNT_W-1:0]   cnt_reg        = '0;
        logic [CNT_W-1:0]   cnt_next;
        logic [RETRY_W-1:0] retry_reg      = '0;
        logic [RETRY_W-1:0] retry_next;

        logic               gt_reg         = 1'b1;
        logic               ra_reg         = 1'b1;
        logic               txrx_reg       = 1'b1;
        logic               ok_reg         = 1'b0;
        logic               fail_reg       = 1'b0;
        logic [RETRY_W-1:0] retry_out_reg  = '0;
        logic               gt_next;
        logic               ra_next;
        logic               txrx_next;
        logic               ok_next;
        logic               fail_next;

        // Two-flop synchroniser for the asynchronous channel_up.
        always_ff @(posedge init_clk) begin
            if (RST) begin
                ch_up_meta_reg <= 1'b0;
                ch_up_s_reg    <= 1'b0;
            end else begin
                ch_up_meta_reg <= channel_up[gi];
                ch_up_s_reg    <= ch_up_meta_reg;
            end
        end

        // State register plus the registered output decode.
        always_ff @(posedge init_clk) begin
            if (RST) begin
                state_reg     <= RESET_GT;
                cnt_reg       <= '0;
                retry_reg     <= '0;
                gt_reg        <= 1'b1;
                ra_reg        <= 1'b1;
                txrx_reg      <= 1'b1;
                ok_reg        <= 1'b0;
                fail_reg      <= 1'b0;
                retry_out_reg <= '0;
            end else begin
                state_reg     <= state_next;
                cnt_reg       <= cnt_next;
                retry_reg     <= retry_next;
                gt_reg        <= gt_next;
                ra_reg        <= ra_next;
                txrx_reg      <= txrx_next;
                ok_reg        <= ok_next;
                fail_reg      <= fail_next;
                retry_out_reg <= retry_reg;
            end
        end

        // Next-state logic. force_reinit is checked first so it wins over
        // channel_up and the timeout in the same cycle.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            retry_next = retry_reg;
            if (force_reinit[gi]) begin
                state_next = RESET_GT;
                cnt_next   = '0;
                retry_next = '0;
            end else begin
                case (state_reg)
                    RESET_GT: begin
                        if (cnt_reg == GT_LAST) begin
                            state_next = RESET_CORE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    RESET_CORE: begin
                        if (cnt_reg == CORE_LAST) begin
                            state_next = WAIT_UP;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    WAIT_UP: begin
                        if (ch_up_s_reg) begin
                            // The sample that triggers the move is the first
                            // good one, so debounce starts at 1.
                            state_next = DEBOUNCE;
                            cnt_next   = CNT_W'(1);
                        end else if (cnt_reg == TO_LAST) begin
                            cnt_next = '0;
                            if (retry_reg < RETRY_MAX) begin
                                state_next = RESET_GT;
                                retry_next = retry_reg + 1'b1;
                            end else begin
                                state_next = FAILED;
                            end
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!ch_up_s_reg) begin
                            state_next = WAIT_UP;
                            cnt_next   = '0;
                        end else if (cnt_reg == DEB_LAST) begin
                            state_next = LINKED;
                            cnt_next   = '0;
                            retry_next = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    LINKED: begin
                        // Link loss only drops back to waiting; the GT and
                        // core are left running.
                        if (!ch_up_s_reg) begin
                            state_next = WAIT_UP;
                            cnt_next   = '0;
                        end
                    end
                    FAILED: begin
                        state_next = FAILED;
                    end
                    default: begin
                        state_next = RESET_GT;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        // Output decode from the current state; registered above.
        always_comb begin
            gt_next   = 1'b1;
            ra_next   = 1'b1;
            txrx_next = 1'b1;
            ok_next   = 1'b0;
            fail_next = 1'b0;
            case (state_reg)
                RESET_CORE: gt_next = 1'b0;
                WAIT_UP, DEBOUNCE: begin
                    gt_next = 1'b0;
                    ra_next = 1'b0;
                end
                LINKED: begin
                    gt_next   = 1'b0;
                    ra_next   = 1'b0;
                    txrx_next = 1'b0;
                    ok_next   = 1'b1;
                end
                FAILED:  fail_next = 1'b1;
                default: ;
            endcase
        end

        assign gt_reset[gi]          = gt_reg;
        assign reset_Aurora[gi]      = ra_reg;
        assign reset_TX_RX_Block[gi] = txrx_reg;
        assign link_ok[gi]           = ok_reg;
        assign link_fail[gi]         = fail_reg;
        assign retry_cnt[4*gi +: 4]  = 4'(retry_out_reg);
    end

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Bench for aurora_reset_sequencer with two channels, TIMEOUT=64, MAX_RETRY=2.
// Expected output vectors {gt, ra, txrx, ok, fail, retry[3:0]} are queued with
// the edge number at which they must appear and compared on the falling edge.
module tb_aurora_reset_sequencer;

    localparam int N_CH      = 2;
    localparam int GT_HOLD   = 14;
    localparam int CORE_HOLD = 4;
    localparam int DEB_LEN   = 8;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 2;

    logic              init_clk = 1'b0;
    logic              RST = 1'b1;
    logic [N_CH-1:0]   channel_up = '0;
    logic [N_CH-1:0]   force_reinit = '0;
    logic [N_CH-1:0]   gt_reset;
    logic [N_CH-1:0]   reset_Aurora;
    logic [N_CH-1:0]   reset_TX_RX_Block;
    logic [N_CH-1:0]   link_ok;
    logic [N_CH-1:0]   link_fail;
    logic [4*N_CH-1:0] retry_cnt;

    aurora_reset_sequencer #(
        .N_CH(N_CH), .GT_HOLD(GT_HOLD), .CORE_HOLD(CORE_HOLD),
        .DEB_LEN(DEB_LEN), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .init_clk(init_clk),
        .RST(RST),
        .channel_up(channel_up),
        .force_reinit(force_reinit),
        .gt_reset(gt_reset),
        .reset_Aurora(reset_Aurora),
        .reset_TX_RX_Block(reset_TX_RX_Block),
        .link_ok(link_ok),
        .link_fail(link_fail),
        .retry_cnt(retry_cnt)
    );

    always #5 init_clk = ~init_clk;

    // Number of rising edges seen so far; stable when read on a falling edge.
    int cyc = 0;
    always @(posedge init_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int base;

    typedef struct {
        int         cyc;
        int         ch;
        logic [8:0] exp;
        string      name;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] up;
        logic [1:0] frc;
    } stim_t;

    exp_t  sb[$];
    stim_t stim_q[$];

    function automatic logic [8:0] vec(logic gt, logic ra, logic tx, logic ok,
                                       logic fl, logic [3:0] r);
        return {gt, ra, tx, ok, fl, r};
    endfunction

    function automatic logic [8:0] observe(int ch);
        return {gt_reset[ch], reset_Aurora[ch], reset_TX_RX_Block[ch],
                link_ok[ch], link_fail[ch], retry_cnt[4*ch +: 4]};
    endfunction

    task automatic expect_at(int c, int ch, logic [8:0] e, string n);
        exp_t x;
        x.cyc = c; x.ch = ch; x.exp = e; x.name = n;
        sb.push_back(x);
    endtask

    task automatic stim_at(int c, logic [1:0] up, logic [1:0] frc);
        stim_t s;
        s.cyc = c; s.up = up; s.frc = frc;
        stim_q.push_back(s);
    endtask

    // Applied on the falling edge after edge s.cyc, so sampled at s.cyc+1.
    task automatic drive_stim();
        stim_t s;
        while (stim_q.size() != 0 && stim_q[0].cyc <= cyc) begin
            s = stim_q.pop_front();
            channel_up   = s.up;
            force_reinit = s.frc;
        end
    endtask

    localparam logic [8:0] LINKED_V = 9'b000_1_0_0000;

    task automatic test_reset();
        exp_t e;
        logic [8:0] got;
        @(negedge init_clk);
        RST = 1'b1; force_reinit = 2'b11; channel_up = 2'b00;
        repeat (3) @(negedge init_clk);
        base = cyc;
        RST = 1'b0; force_reinit = 2'b00;
        expect_at(base,      0, vec(1,1,1,0,0,0), "reset_state_ch0");
        expect_at(base,      1, vec(1,1,1,0,0,0), "reset_state_ch1");
        expect_at(base + 14, 0, vec(1,1,1,0,0,0), "gt_held");
        expect_at(base + 15, 0, vec(0,1,1,0,0,0), "gt_fall_ch0");
        expect_at(base + 15, 1, vec(0,1,1,0,0,0), "gt_fall_ch1");
        expect_at(base + 18, 0, vec(0,1,1,0,0,0), "core_held");
        expect_at(base + 19, 0, vec(0,0,1,0,0,0), "core_fall");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
    endtask

    // ch0 comes up cleanly; ch1 sees 1,1,1,0 before settling high.
    task automatic test_link_and_glitch();
        exp_t e;
        logic [8:0] got;
        stim_at(base + 29, 2'b11, 2'b00);
        stim_at(base + 32, 2'b01, 2'b00);
        stim_at(base + 33, 2'b11, 2'b00);
        expect_at(base + 39, 0, vec(0,0,1,0,0,0), "debounce_not_done");
        expect_at(base + 40, 0, LINKED_V,         "link_ch0");
        expect_at(base + 40, 1, vec(0,0,1,0,0,0), "glitch_not_linked");
        expect_at(base + 43, 1, vec(0,0,1,0,0,0), "glitch_debounce_end");
        expect_at(base + 44, 1, LINKED_V,         "glitch_link_ch1");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
    endtask

    // ch0 loses channel_up for good: link drop, two retries, then FAILED.
    task automatic test_drop_and_retry();
        exp_t e;
        logic [8:0] got;
        int d;
        d = base + 50;
        stim_at(d, 2'b10, 2'b00);
        expect_at(d + 3,   0, LINKED_V,         "drop_still_linked");
        expect_at(d + 4,   0, vec(0,0,1,0,0,0), "drop_txrx_reset");
        expect_at(d + 4,   1, LINKED_V,         "drop_ch1_unaffected");
        expect_at(d + 67,  0, vec(0,0,1,0,0,0), "pre_timeout1");
        expect_at(d + 68,  0, vec(1,1,1,0,0,1), "retry1");
        expect_at(d + 82,  0, vec(0,1,1,0,0,1), "retry1_gt_fall");
        expect_at(d + 86,  0, vec(0,0,1,0,0,1), "retry1_wait");
        expect_at(d + 149, 0, vec(0,0,1,0,0,1), "pre_timeout2");
        expect_at(d + 150, 0, vec(1,1,1,0,0,2), "retry2");
        expect_at(d + 231, 0, vec(0,0,1,0,0,2), "pre_fail");
        expect_at(d + 232, 0, vec(1,1,1,0,1,2), "failed");
        expect_at(d + 232, 1, LINKED_V,         "fail_ch1_unaffected");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
        base = d;
    endtask

    // FAILED ignores channel_up; force_reinit leaves it, and a second pulse
    // inside RESET_GT restarts the hold count.
    task automatic test_force_reinit();
        exp_t e;
        logic [8:0] got;
        int f;
        f = base + 240;
        stim_at(base + 235, 2'b11, 2'b00);
        stim_at(f,          2'b11, 2'b01);
        stim_at(f + 1,      2'b11, 2'b00);
        stim_at(f + 5,      2'b11, 2'b01);
        stim_at(f + 6,      2'b11, 2'b00);
        expect_at(f,      0, vec(1,1,1,0,1,2), "failed_sticky");
        expect_at(f + 2,  0, vec(1,1,1,0,0,0), "force_from_failed");
        expect_at(f + 20, 0, vec(1,1,1,0,0,0), "restart_gt_held");
        expect_at(f + 21, 0, vec(0,1,1,0,0,0), "restart_gt_fall");
        expect_at(f + 25, 0, vec(0,0,1,0,0,0), "restart_wait");
        expect_at(f + 32, 0, vec(0,0,1,0,0,0), "restart_debounce");
        expect_at(f + 33, 0, LINKED_V,         "relinked_ch0");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
        base = f;
    endtask

    // Both linked; reinit ch1 only.
    task automatic test_independent();
        exp_t e;
        logic [8:0] got;
        int g;
        g = base + 40;
        stim_at(g,     2'b11, 2'b10);
        stim_at(g + 1, 2'b11, 2'b00);
        expect_at(g + 1,  1, LINKED_V,         "pre_force_ch1");
        expect_at(g + 2,  1, vec(1,1,1,0,0,0), "ch1_resequence");
        expect_at(g + 2,  0, LINKED_V,         "ch0_unchanged");
        expect_at(g + 15, 1, vec(1,1,1,0,0,0), "ch1_gt_held");
        expect_at(g + 16, 1, vec(0,1,1,0,0,0), "ch1_gt_fall");
        expect_at(g + 16, 0, LINKED_V,         "ch0_steady");
        expect_at(g + 28, 1, LINKED_V,         "ch1_relinked");
        expect_at(g + 28, 0, LINKED_V,         "ch0_final");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
        base = g;
    endtask

    // RST while linked, together with force_reinit: plain restart.
    task automatic test_reset_linked();
        exp_t e;
        logic [8:0] got;
        int h;
        h = base + 35;
        while (cyc < h) begin @(negedge init_clk); drive_stim(); end
        RST = 1'b1; force_reinit = 2'b11;
        @(negedge init_clk);
        RST = 1'b0; force_reinit = 2'b00;
        expect_at(h + 1,  0, vec(1,1,1,0,0,0), "rst_linked_ch0");
        expect_at(h + 1,  1, vec(1,1,1,0,0,0), "rst_linked_ch1");
        expect_at(h + 15, 0, vec(1,1,1,0,0,0), "rst_gt_held");
        expect_at(h + 16, 0, vec(0,1,1,0,0,0), "rst_gt_fall");
        expect_at(h + 27, 0, vec(0,0,1,0,0,0), "rst_debounce");
        expect_at(h + 28, 0, LINKED_V,         "rst_relink_ch0");
        expect_at(h + 28, 1, LINKED_V,         "rst_relink_ch1");
        while (sb.size() != 0) begin
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); got = observe(e.ch); checks++;
                if (e.cyc != cyc || got !== e.exp) begin
                    failures++;
                    $display("FAIL %s ch%0d edge=%0d got=%b expected=%b", e.name, e.ch, cyc, got, e.exp);
                end else $display("check %s ch%0d edge=%0d value=%b ok", e.name, e.ch, cyc, got);
            end
            if (sb.size() != 0) begin @(negedge init_clk); drive_stim(); end
        end
    endtask

    initial begin
        test_reset();
        test_link_and_glitch();
        test_drop_and_retry();
        test_force_reinit();
        test_independent();
        test_reset_linked();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d got=timeout expected=completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
